// File: rtl/ascii_field_scanner.sv
// rtl/ascii_field_scanner.sv - ASCII numeric field scanner (bin/oct/dec/hex text to binary values)
//
// Purpose:
//   Consumes a byte-wide ASCII character stream and parses delimiter-separated
//   numeric fields. Each field produces one WIDTH-bit value on a valid/ready
//   output, tagged with overflow, error and end-of-line flags.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   radix[1:0]      00=dec 01=bin 10=oct 11=hex, sampled at the first digit of a field
//   in_valid/in_ready/in_char   character input handshake
//   out_valid/out_ready         field output handshake
//   out_value       parsed value (low WIDTH bits)
//   out_overflow    significant bits were lost beyond WIDTH
//   out_error       field contained an illegal character (value forced to 0)
//   out_eol         field was terminated by LF
//   out_xzmask      (only with ASCII_FIELD_SCANNER_XZ_EN) bit positions given as x/z
//
// Optional feature macro: ASCII_FIELD_SCANNER_XZ_EN
//   When defined, x/X/z/Z are accepted as unknown digits and reported in out_xzmask.

module ascii_field_scanner #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       radix,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_char,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic             out_overflow,
    output logic             out_error,
    output logic             out_eol
`ifdef ASCII_FIELD_SCANNER_XZ_EN
    ,
    output logic [WIDTH-1:0] out_xzmask
`endif
);

    localparam logic [1:0] RDX_DEC = 2'b00;
    localparam logic [1:0] RDX_BIN = 2'b01;
    localparam logic [1:0] RDX_OCT = 2'b10;
    localparam logic [1:0] RDX_HEX = 2'b11;

    // Accumulator arithmetic is done 4 bits wider so that anything shifted or
    // carried out of the WIDTH-bit result can be detected as overflow.
    localparam int WW = WIDTH + 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ACCUM = 2'b01,
        S_SKIP  = 2'b10,
        S_EMIT  = 2'b11
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       radix_q, radix_d;
    logic [WIDTH-1:0] out_value_q, out_value_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_err_q, out_err_d;
    logic             out_eol_q, out_eol_d;

    // ------------------------------------------------------------------
    // Character classification
    // ------------------------------------------------------------------
    logic       is_lf;
    logic       is_delim;
    logic       is_us;
    logic       is_dec;
    logic       is_hex;
    logic       is_xz;
    logic [3:0] dig_val;

    always_comb begin
        is_lf    = (in_char == 8'h0A);
        is_delim = (in_char == 8'h20) || (in_char == 8'h09) || (in_char == 8'h2C) ||
                   is_lf || (in_char == 8'h0D);
        is_us    = (in_char == 8'h5F);
        is_dec   = 1'b0;
        is_hex   = 1'b0;
        dig_val  = 4'd0;
        if ((in_char >= 8'h30) && (in_char <= 8'h39)) begin
            is_dec  = 1'b1;
            is_hex  = 1'b1;
            dig_val = in_char[3:0];
        end else if (((in_char >= 8'h61) && (in_char <= 8'h66)) ||
                     ((in_char >= 8'h41) && (in_char <= 8'h46))) begin
            // 'a'/'A' have low nibble 1, so +9 maps them onto 10..15.
            is_hex  = 1'b1;
            dig_val = in_char[3:0] + 4'd9;
        end
    end

`ifdef ASCII_FIELD_SCANNER_XZ_EN
    assign is_xz = (in_char == 8'h78) || (in_char == 8'h58) ||
                   (in_char == 8'h7A) || (in_char == 8'h5A);
`else
    assign is_xz = 1'b0;
`endif

    // A field set up by a sole decimal x/z digit accepts nothing but a delimiter.
    logic xz_sole;

    // The radix input is only consulted for the first digit; afterwards the
    // latched copy decides legality and arithmetic.
    logic [1:0] cur_radix;
    logic       dig_legal;

    assign cur_radix = (state_q == S_IDLE) ? radix : radix_q;

    always_comb begin
        dig_legal = 1'b0;
        case (cur_radix)
            RDX_DEC: dig_legal = is_dec || (is_xz && (state_q == S_IDLE));
            RDX_BIN: dig_legal = (is_dec && (dig_val <= 4'd1)) || is_xz;
            RDX_OCT: dig_legal = (is_dec && (dig_val <= 4'd7)) || is_xz;
            default: dig_legal = is_hex || is_xz;
        endcase
    end

    // ------------------------------------------------------------------
    // Event decode: what the accepted character does this cycle
    // ------------------------------------------------------------------
    logic take;
    logic start_field;
    logic start_err;
    logic add_digit;
    logic ignore_us;
    logic accum_err;
    logic emit_acc;
    logic emit_err;
    logic handshake;

    assign take        = in_valid && in_ready;
    assign start_field = take && (state_q == S_IDLE) && !is_delim && dig_legal;
    assign start_err   = take && (state_q == S_IDLE) && !is_delim && !dig_legal;
    assign add_digit   = take && (state_q == S_ACCUM) && !is_delim && dig_legal && !xz_sole;
    assign ignore_us   = take && (state_q == S_ACCUM) && is_us && !xz_sole;
    assign accum_err   = take && (state_q == S_ACCUM) && !is_delim && !add_digit && !ignore_us;
    assign emit_acc    = take && (state_q == S_ACCUM) && is_delim;
    assign emit_err    = take && (state_q == S_SKIP) && is_delim;
    assign handshake   = (state_q == S_EMIT) && out_ready;

    // ------------------------------------------------------------------
    // Accumulator arithmetic
    // ------------------------------------------------------------------
    logic [WW-1:0] acc_ext;
    logic [WW-1:0] acc_prod;
    logic [WW-1:0] acc_wide;
    logic          acc_carry;

    always_comb begin
        acc_ext = {4'b0000, acc_q};
        case (radix_q)
            RDX_BIN: acc_prod = acc_ext << 1;
            RDX_OCT: acc_prod = acc_ext << 3;
            RDX_HEX: acc_prod = acc_ext << 4;
            default: acc_prod = (acc_ext << 3) + (acc_ext << 1);
        endcase
        acc_wide  = acc_prod + {{WIDTH{1'b0}}, dig_val};
        acc_carry = |acc_wide[WW-1:WIDTH];
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_field) begin
                    state_d = S_ACCUM;
                end else if (start_err) begin
                    state_d = S_SKIP;
                end
            end
            S_ACCUM: begin
                if (emit_acc) begin
                    state_d = S_EMIT;
                end else if (accum_err) begin
                    state_d = S_SKIP;
                end
            end
            S_SKIP: begin
                if (emit_err) begin
                    state_d = S_EMIT;
                end
            end
            default: begin
                if (handshake) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = !rst && (state_q != S_EMIT);
        out_valid = (state_q == S_EMIT);
    end

    assign out_value    = out_value_q;
    assign out_overflow = out_ovf_q;
    assign out_error    = out_err_q;
    assign out_eol      = out_eol_q;

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        radix_d     = radix_q;
        out_value_d = out_value_q;
        out_ovf_d   = out_ovf_q;
        out_err_d   = out_err_q;
        out_eol_d   = out_eol_q;

        if (start_field) begin
            acc_d   = WIDTH'(dig_val);
            ovf_d   = 1'b0;
            radix_d = radix;
        end

        if (add_digit) begin
            acc_d = acc_wide[WIDTH-1:0];
            ovf_d = ovf_q || acc_carry;
        end

        if (emit_acc) begin
            out_value_d = acc_q;
            out_ovf_d   = ovf_q;
            out_err_d   = 1'b0;
            out_eol_d   = is_lf;
        end

        if (emit_err) begin
            out_value_d = '0;
            out_ovf_d   = 1'b0;
            out_err_d   = 1'b1;
            out_eol_d   = is_lf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            radix_q     <= RDX_DEC;
            out_value_q <= '0;
            out_ovf_q   <= 1'b0;
            out_err_q   <= 1'b0;
            out_eol_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            radix_q     <= radix_d;
            out_value_q <= out_value_d;
            out_ovf_q   <= out_ovf_d;
            out_err_q   <= out_err_d;
            out_eol_q   <= out_eol_d;
        end
    end

    // ------------------------------------------------------------------
    // Unknown-digit mask
    // ------------------------------------------------------------------
`ifdef ASCII_FIELD_SCANNER_XZ_EN
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] out_mask_q, out_mask_d;
    logic             xz_sole_q, xz_sole_d;
    logic [WIDTH-1:0] dig_mask;
    logic [WIDTH-1:0] mask_shifted;

    assign xz_sole = xz_sole_q;

    // Bits covered by one digit; a decimal x/z stands for the whole value.
    always_comb begin
        case (cur_radix)
            RDX_BIN: dig_mask = WIDTH'(1);
            RDX_OCT: dig_mask = WIDTH'(7);
            RDX_HEX: dig_mask = WIDTH'(15);
            default: dig_mask = '1;
        endcase
    end

    // The mask moves with the accumulator; decimal fields never shift it
    // because an x/z there is only legal as the sole digit.
    always_comb begin
        case (radix_q)
            RDX_BIN: mask_shifted = mask_q << 1;
            RDX_OCT: mask_shifted = mask_q << 3;
            RDX_HEX: mask_shifted = mask_q << 4;
            default: mask_shifted = mask_q;
        endcase
    end

    always_comb begin
        mask_d     = mask_q;
        out_mask_d = out_mask_q;
        xz_sole_d  = xz_sole_q;

        if (start_field) begin
            mask_d    = is_xz ? dig_mask : '0;
            xz_sole_d = is_xz && (radix == RDX_DEC);
        end
        if (start_err || accum_err) begin
            mask_d    = '0;
            xz_sole_d = 1'b0;
        end
        if (add_digit) begin
            mask_d = mask_shifted | (is_xz ? dig_mask : '0);
        end
        if (emit_acc) begin
            out_mask_d = mask_q;
        end
        if (emit_err) begin
            out_mask_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q     <= '0;
            out_mask_q <= '0;
            xz_sole_q  <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            out_mask_q <= out_mask_d;
            xz_sole_q  <= xz_sole_d;
        end
    end

    assign out_xzmask = out_mask_q;
`else
    assign xz_sole = 1'b0;
`endif

endmodule

// File: tb/tb_ascii_field_scanner.sv
// tb/tb_ascii_field_scanner.sv - self-checking bench for ascii_field_scanner

module tb_ascii_field_scanner;

    typedef struct {
        int          id;
        logic [31:0] value;
        bit          ovf;
        bit          err;
        bit          eol;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  radix;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_value;
    logic        out_overflow;
    logic        out_error;
    logic        out_eol;
`ifdef ASCII_FIELD_SCANNER_XZ_EN
    logic [31:0] out_xzmask;
`endif

    ascii_field_scanner #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .radix        (radix),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_char      (in_char),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_value    (out_value),
        .out_overflow (out_overflow),
        .out_error    (out_error),
        .out_eol      (out_eol)
`ifdef ASCII_FIELD_SCANNER_XZ_EN
        ,
        .out_xzmask   (out_xzmask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total;
    int          bad;
    byte unsigned chars_q[$];
    bit [1:0]    rdx_q[$];
    exp_t        exp_q[$];
    exp_t        tbl[$];
    string       txt[6];
    bit [1:0]    trad[6];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic int digval(input byte unsigned c);
        if (c >= 48 && c <= 57) return int'(c) - 48;
        if (c >= 97 && c <= 102) return int'(c) - 87;
        if (c >= 65 && c <= 70) return int'(c) - 55;
        return 99;
    endfunction

    function automatic bit is_delim_ch(input byte unsigned c);
        return (c == 32) || (c == 9) || (c == 44) || (c == 10) || (c == 13);
    endfunction

    // Reference: split the text into tokens between delimiters and evaluate
    // each token as a number in the radix seen at its first character.
    function automatic void model_build();
        bit              in_tok;
        bit              terr;
        bit              tovf;
        longint unsigned v;
        int              base;
        int              d;
        exp_t            e;
        in_tok = 0; terr = 0; tovf = 0; v = 0; base = 10;
        for (int i = 0; i < chars_q.size(); i++) begin
            if (is_delim_ch(chars_q[i])) begin
                if (in_tok) begin
                    e.id    = 0;
                    e.value = terr ? 32'd0 : v[31:0];
                    e.ovf   = terr ? 1'b0 : tovf;
                    e.err   = terr;
                    e.eol   = (chars_q[i] == 10);
                    exp_q.push_back(e);
                end
                in_tok = 0;
            end else if (!in_tok) begin
                in_tok = 1;
                case (rdx_q[i])
                    2'd0: base = 10;
                    2'd1: base = 2;
                    2'd2: base = 8;
                    default: base = 16;
                endcase
                d    = digval(chars_q[i]);
                terr = (d >= base);
                tovf = 0;
                v    = terr ? 0 : longint'(d);
            end else if (!terr && chars_q[i] != 95) begin
                d = digval(chars_q[i]);
                if (d >= base) begin
                    terr = 1;
                end else begin
                    v = v * longint'(base) + longint'(d);
                    if (v >= 64'h1_0000_0000) begin
                        tovf = 1;
                        v    = v % 64'h1_0000_0000;
                    end
                end
            end
        end
    endfunction

    function automatic void load(input string s, input bit [1:0] r);
        chars_q.delete();
        rdx_q.delete();
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            chars_q.push_back(s[i]);
            rdx_q.push_back(r);
        end
    endfunction

    // mode 0: random input gaps and random out_ready
    // mode 1: continuous input, each field stalled 5 cycles before out_ready
    // Called and returns at #1 after a rising edge.
    task automatic run_stream(input int mode, input int budget);
        int          idx;
        int          cyc;
        int          viol;
        int          extra;
        int          stall;
        int          late;
        bit          acc;
        bit          fire;
        logic [34:0] got;
        exp_t        x;
        idx = 0; cyc = 0; viol = 0; extra = 0; stall = 0; late = 0;
        while ((idx < chars_q.size() || exp_q.size() != 0) && cyc < budget) begin
            if (idx < chars_q.size()) begin
                in_char  = chars_q[idx];
                radix    = rdx_q[idx];
                in_valid = (mode == 1) ? 1'b1 : ($urandom_range(0, 9) < 8);
            end else begin
                in_valid = 1'b0;
                in_char  = 8'h00;
            end
            out_ready = (mode == 1) ? (stall >= 5) : ($urandom_range(0, 9) < 7);
            @(negedge clk);
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (out_valid && in_ready) viol++;
            if (out_valid && !out_ready) stall++;
            got = {out_value, out_overflow, out_error, out_eol};
            @(posedge clk);
            #1;
            cyc++;
            if (acc) idx++;
            if (fire) begin
                stall = 0;
                if (exp_q.size() == 0) begin
                    extra++;
                end else begin
                    x = exp_q.pop_front();
                    chk("field", 64'(got), 64'({x.value, x.ovf, x.err, x.eol}));
                end
            end
        end
        chk("stream_done", 64'(chars_q.size() - idx + exp_q.size()), 64'(0));
        chk("in_ready_low_in_emit", 64'(viol), 64'(0));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) late++;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        chk("extra_fields", 64'(extra + late), 64'(0));
    endtask

    initial begin
        exp_t e;
        int   ntok;
        int   len;
        int   p;
        string digs;
        string ills;
        string dels;

        total = 0; bad = 0;
        rst = 1'b1; in_valid = 1'b0; in_char = 8'h00; radix = 2'b00; out_ready = 1'b0;

        txt[0] = "1aF,";                        trad[0] = 2'd3;
        txt[1] = "4294967295 4294967296\n";     trad[1] = 2'd0;
        txt[2] = "10_1,12 ,\n";                 trad[2] = 2'd1;
        txt[3] = "FFFFFFFF FFFFFFFF1\n";        trad[3] = 2'd3;
        txt[4] = "_5 9\r07\t";                  trad[4] = 2'd2;
        txt[5] = "a\n  \n 0012_,g ";            trad[5] = 2'd0;
        tbl.push_back('{0, 32'h000001AF, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1, 32'h00000000, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{2, 32'h00000005, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{2, 32'h00000000, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{3, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{3, 32'hFFFFFFF1, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{4, 32'h00000000, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{4, 32'h00000000, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{4, 32'h00000007, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{5, 32'h00000000, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{5, 32'h0000000C, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{5, 32'h00000000, 1'b0, 1'b1, 1'b0});

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'(0));
        chk("reset_outputs", 64'({out_valid, out_value, out_overflow, out_error, out_eol}), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Latency: delimiter accepted at edge N gives out_valid right after N
        radix = 2'd0; in_valid = 1'b1; in_char = 8'h35;
        @(posedge clk);
        #1 in_char = 8'h20;
        @(negedge clk);
        chk("latency_before", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("latency_emit", 64'({out_valid, out_value, out_overflow, out_error, out_eol}),
            64'({1'b1, 32'd5, 1'b0, 1'b0, 1'b0}));
        chk("emit_in_ready", 64'(in_ready), 64'(0));
        // Reset while the field is pending drops it
        rst = 1'b1;
        #1;
        chk("reset_drops_emit", 64'({out_valid, out_value}), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed table
        for (int k = 0; k < 6; k++) begin
            load(txt[k], trad[k]);
            foreach (tbl[j]) if (tbl[j].id == k) exp_q.push_back(tbl[j]);
            run_stream(0, 400);
        end

        // Backpressure
        load("7 8 ", 2'd0);
        exp_q.push_back('{0, 32'd7, 1'b0, 1'b0, 1'b0});
        exp_q.push_back('{0, 32'd8, 1'b0, 1'b0, 1'b0});
        run_stream(1, 200);

        // Reset in the middle of a field
        load("12", 2'd0);
        run_stream(0, 100);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_mid_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        load(" 3\n", 2'd0);
        exp_q.push_back('{0, 32'd3, 1'b0, 1'b0, 1'b1});
        run_stream(0, 100);

`ifdef ASCII_FIELD_SCANNER_XZ_EN
        radix = 2'd3; out_ready = 1'b0; in_valid = 1'b1; in_char = 8'h31;
        @(posedge clk);
        #1 in_char = 8'h78;
        @(posedge clk);
        #1 in_char = 8'h0A;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("xz_field", 64'({out_valid, out_value, out_error, out_eol}),
            64'({1'b1, 32'h10, 1'b0, 1'b1}));
        chk("xz_mask", 64'(out_xzmask), 64'(32'h0F));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
`endif

        // Randomized streams against the reference model
        digs = "0123456789abcdefABCDEF";
        ills = "gG?#";
        dels = " \t,\r\n";
        for (int s = 0; s < 40; s++) begin
            chars_q.delete();
            rdx_q.delete();
            exp_q.delete();
            ntok = $urandom_range(1, 6);
            for (int t = 0; t < ntok; t++) begin
                len = $urandom_range(0, 12);
                for (int c = 0; c < len; c++) begin
                    p = $urandom_range(0, 99);
                    if (p < 80)      chars_q.push_back(digs[$urandom_range(0, 21)]);
                    else if (p < 88) chars_q.push_back(8'h5F);
                    else             chars_q.push_back(ills[$urandom_range(0, 3)]);
                    rdx_q.push_back(2'($urandom_range(0, 3)));
                end
                chars_q.push_back(dels[$urandom_range(0, 4)]);
                rdx_q.push_back(2'($urandom_range(0, 3)));
            end
            chars_q.push_back(8'h0A);
            rdx_q.push_back(2'd0);
            model_build();
            run_stream(0, 2000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
